// File: rtl/sd_ctrl_pkg.sv
// sd_ctrl_pkg
// Shared definitions for the SD controller command path: response frame
// lengths, the CRC7 generator polynomial and the response receiver state
// encoding.
package sd_ctrl_pkg;

    // Total frame lengths on the CMD line, start bit through end bit.
    localparam int RSP_SHORT_BITS = 48;
    localparam int RSP_LONG_BITS  = 136;

    // CRC7 generator x^7 + x^3 + 1 with the x^7 term implied.
    localparam logic [6:0] CRC7_POLY = 7'h09;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RECV = 2'd2,
        FIN  = 2'd3
    } rsp_state_t;

endpackage

// File: rtl/sd_rsp_crc7.sv
// sd_rsp_crc7
// Serial CRC7 accumulator, one data bit per enabled clock.
// Ports:
//   CLK  - clock
//   RST  - synchronous active-high reset, clears the register
//   clr  - restart the accumulation; when en is also high the data bit is
//          folded into a zero register in the same cycle
//   en   - fold din into the CRC this cycle
//   din  - serial data bit, MSB of the protected field first
//   crc  - current CRC7 remainder
module sd_rsp_crc7
    import sd_ctrl_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    input  logic       clr,
    input  logic       en,
    input  logic       din,
    output logic [6:0] crc
);

    logic [6:0] base;
    logic [6:0] crc_nxt;
    logic       inv;

    // Clearing and updating in the same cycle starts a fresh CRC with this bit.
    always_comb begin
        base    = clr ? 7'h00 : crc;
        inv     = din ^ base[6];
        crc_nxt = {base[5:0], 1'b0} ^ (inv ? CRC7_POLY : 7'h00);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            crc <= 7'h00;
        end else if (en) begin
            crc <= crc_nxt;
        end else if (clr) begin
            crc <= 7'h00;
        end
    end

endmodule

// File: rtl/sd_cmd_rsp_rx.sv
// sd_cmd_rsp_rx
// Receives the card's response on the CMD line after a command has been sent.
// Waits up to NCR_MAX cycles for the start bit, then deserializes a 48-bit
// short or 136-bit long (R2) response while running CRC7 over the protected
// bits, and reports the fields and status to the command FSM.
// Ports:
//   CLK, RST     - clock, synchronous active-high reset
//   arm          - one-cycle start pulse, honoured only in IDLE
//   long_rsp     - sampled at arm, selects a 136-bit R2 response
//   crc_chk_en   - sampled at arm, 0 suppresses crc_err
//   cmd_in       - sampled CMD line, idles high
//   busy         - receive in progress
//   done         - one-cycle completion pulse
//   rsp_index    - command index (short) or reserved bits (long)
//   rsp_data     - argument (short, zero-extended) or bits 127:0 (long)
//   crc_err, end_err, tx_err, timeout - status, valid at done, held to next arm
module sd_cmd_rsp_rx
    import sd_ctrl_pkg::*;
#(
    parameter int NCR_MAX = 64,
    parameter int CNT_W   = 8
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         arm,
    input  logic         long_rsp,
    input  logic         crc_chk_en,
    input  logic         cmd_in,
    output logic         busy,
    output logic         done,
    output logic [5:0]   rsp_index,
    output logic [127:0] rsp_data,
    output logic         crc_err,
    output logic         end_err,
    output logic         tx_err,
    output logic         timeout
);

    localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(NCR_MAX - 1);
    localparam logic [CNT_W-1:0] SHORT_TOP  = CNT_W'(RSP_SHORT_BITS - 2);
    localparam logic [CNT_W-1:0] LONG_TOP   = CNT_W'(RSP_LONG_BITS - 2);
    localparam logic [CNT_W-1:0] LONG_CRC_HI = CNT_W'(127);
    localparam logic [CNT_W-1:0] CRC_LO     = CNT_W'(8);

    rsp_state_t       state;
    rsp_state_t       state_nxt;
    logic             long_q;
    logic             chk_q;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] bit_cnt;
    logic [134:0]     sh;
    logic [134:0]     sh_nxt;
    logic             crc_clr;
    logic             crc_en;
    logic [6:0]       crc;
    logic             wait_last;
    logic             last_bit;

    assign wait_last = (wait_cnt == WAIT_LAST);
    assign last_bit  = (bit_cnt == '0);
    assign sh_nxt    = {sh[133:0], cmd_in};

    assign busy = (state == WAIT) || (state == RECV);
    assign done = (state == FIN);

    sd_rsp_crc7 u_crc (
        .CLK (CLK),
        .RST (RST),
        .clr (crc_clr),
        .en  (crc_en),
        .din (cmd_in),
        .crc (crc)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and CRC window control. A short response also protects the
    // start bit, which is only visible on the WAIT->RECV transition; a long
    // response restarts the CRC at bit 127 so the header bits never count.
    always_comb begin
        state_nxt = state;
        crc_clr   = 1'b0;
        crc_en    = 1'b0;
        case (state)
            IDLE: begin
                if (arm) begin
                    state_nxt = WAIT;
                    crc_clr   = 1'b1;
                end
            end
            WAIT: begin
                if (!cmd_in) begin
                    state_nxt = RECV;
                    crc_en    = ~long_q;
                end else if (wait_last) begin
                    state_nxt = FIN;
                end
            end
            RECV: begin
                if (long_q) begin
                    crc_clr = (bit_cnt == LONG_CRC_HI);
                    crc_en  = (bit_cnt <= LONG_CRC_HI) && (bit_cnt >= CRC_LO);
                end else begin
                    crc_en  = (bit_cnt >= CRC_LO);
                end
                if (last_bit) begin
                    state_nxt = FIN;
                end
            end
            FIN: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath. At the last bit sh_nxt holds the whole frame after the start
    // bit, so the transmission bit, received CRC and fields are all taken from
    // the shift register in one edge; sh[6:0] is then the received CRC.
    always_ff @(posedge CLK) begin
        if (RST) begin
            long_q    <= 1'b0;
            chk_q     <= 1'b0;
            wait_cnt  <= '0;
            bit_cnt   <= '0;
            sh        <= '0;
            rsp_index <= '0;
            rsp_data  <= '0;
            crc_err   <= 1'b0;
            end_err   <= 1'b0;
            tx_err    <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (arm) begin
                        long_q    <= long_rsp;
                        chk_q     <= crc_chk_en;
                        wait_cnt  <= '0;
                        rsp_index <= '0;
                        rsp_data  <= '0;
                        crc_err   <= 1'b0;
                        end_err   <= 1'b0;
                        tx_err    <= 1'b0;
                        timeout   <= 1'b0;
                    end
                end
                WAIT: begin
                    if (!cmd_in) begin
                        bit_cnt <= long_q ? LONG_TOP : SHORT_TOP;
                    end else if (wait_last) begin
                        timeout <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                RECV: begin
                    sh      <= sh_nxt;
                    bit_cnt <= bit_cnt - 1'b1;
                    if (last_bit) begin
                        crc_err <= (crc != sh[6:0]) & chk_q;
                        end_err <= ~cmd_in;
                        if (long_q) begin
                            tx_err    <= sh_nxt[134];
                            rsp_index <= sh_nxt[133:128];
                            rsp_data  <= sh_nxt[127:0];
                        end else begin
                            tx_err    <= sh_nxt[46];
                            rsp_index <= sh_nxt[45:40];
                            rsp_data  <= {96'b0, sh_nxt[39:8]};
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sd_cmd_rsp_rx.sv
// tb_sd_cmd_rsp_rx
// Directed bench for sd_cmd_rsp_rx: drives response frames on cmd_in and
// compares fields, flags and handshake timing against hand-derived values.
module tb_sd_cmd_rsp_rx;

    logic         CLK = 1'b0;
    logic         RST;
    logic         arm;
    logic         long_rsp;
    logic         crc_chk_en;
    logic         cmd_in;
    logic         busy;
    logic         done;
    logic [5:0]   rsp_index;
    logic [127:0] rsp_data;
    logic         crc_err;
    logic         end_err;
    logic         tx_err;
    logic         timeout;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [47:0] R7_OK = 48'h08_000001AA_13;
    localparam logic [47:0] R3_OK = 48'h3F_00FF8000_FF;

    always #5 CLK = ~CLK;

    sd_cmd_rsp_rx #(.NCR_MAX(64), .CNT_W(8)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .arm        (arm),
        .long_rsp   (long_rsp),
        .crc_chk_en (crc_chk_en),
        .cmd_in     (cmd_in),
        .busy       (busy),
        .done       (done),
        .rsp_index  (rsp_index),
        .rsp_data   (rsp_data),
        .crc_err    (crc_err),
        .end_err    (end_err),
        .tx_err     (tx_err),
        .timeout    (timeout)
    );

    // Reference CRC7 (x^7+x^3+1) over frame bits hi downto lo.
    function automatic logic [6:0] crc7_model(input logic [135:0] f, input int hi, input int lo);
        logic [6:0] c;
        logic       fb;
        c = 7'h00;
        for (int i = hi; i >= lo; i--) begin
            fb = f[i] ^ c[6];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'b000_1001;
        end
        return c;
    endfunction

    task automatic do_arm(input logic lng, input logic chk);
        @(negedge CLK);
        arm        = 1'b1;
        long_rsp   = lng;
        crc_chk_en = chk;
        @(negedge CLK);
        arm = 1'b0;
    endtask

    // Idle-high cycles, then nbits of f MSB first; optionally pulses arm
    // (with different mode bits) while bit arm_at is on the line.
    task automatic drive_frame(input logic [135:0] f, input int nbits, input int idle, input int arm_at);
        for (int k = 0; k < idle; k++) begin
            cmd_in = 1'b1;
            @(negedge CLK);
        end
        for (int i = nbits - 1; i >= 0; i--) begin
            cmd_in = f[i];
            arm    = (i == arm_at);
            if (i == arm_at) begin
                long_rsp   = 1'b1;
                crc_chk_en = 1'b0;
            end
            @(negedge CLK);
        end
        arm    = 1'b0;
        cmd_in = 1'b1;
    endtask

    task automatic test_reset;
        RST = 1'b1; arm = 1'b0; long_rsp = 1'b0; crc_chk_en = 1'b0; cmd_in = 1'b1;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        n_cmp++; if ({busy, done} !== 2'b00) begin n_err++; $display("[TB] FAIL reset_handshake: got busy/done %b want 00", {busy, done}); end
        n_cmp++; if ({crc_err, end_err, tx_err, timeout} !== 4'b0000) begin n_err++; $display("[TB] FAIL reset_flags: got %b want 0000", {crc_err, end_err, tx_err, timeout}); end
        n_cmp++; if ({rsp_index, rsp_data} !== 134'd0) begin n_err++; $display("[TB] FAIL reset_fields: got %h/%h want 0", rsp_index, rsp_data); end
    endtask

    task automatic test_r7;
        do_arm(1'b0, 1'b1);
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("[TB] FAIL r7_busy_after_arm: got %b want 1", busy); end
        drive_frame({88'b0, R7_OK}, 48, 5, -1);
        n_cmp++; if ({done, busy} !== 2'b10) begin n_err++; $display("[TB] FAIL r7_done_latency: got done/busy %b want 10", {done, busy}); end
        n_cmp++; if (rsp_index !== 6'h08) begin n_err++; $display("[TB] FAIL r7_index: got %h want 08", rsp_index); end
        n_cmp++; if (rsp_data !== 128'h1AA) begin n_err++; $display("[TB] FAIL r7_data: got %h want 1aa", rsp_data); end
        n_cmp++; if ({crc_err, end_err, tx_err, timeout} !== 4'b0000) begin n_err++; $display("[TB] FAIL r7_flags: got %b want 0000", {crc_err, end_err, tx_err, timeout}); end
        @(negedge CLK);
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("[TB] FAIL r7_done_pulse_width: got %b want 0", done); end
    endtask

    task automatic test_crc_error;
        logic [47:0] bad;
        bad = R7_OK ^ (48'd1 << 20);
        do_arm(1'b0, 1'b1);
        drive_frame({88'b0, bad}, 48, 2, -1);
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("[TB] FAIL crcerr_done: got %b want 1", done); end
        n_cmp++; if (crc_err !== 1'b1) begin n_err++; $display("[TB] FAIL crcerr_flag: got %b want 1", crc_err); end
        n_cmp++; if (rsp_data !== 128'h11AA) begin n_err++; $display("[TB] FAIL crcerr_data: got %h want 11aa", rsp_data); end
        do_arm(1'b0, 1'b0);
        drive_frame({88'b0, bad}, 48, 1, -1);
        n_cmp++; if (crc_err !== 1'b0) begin n_err++; $display("[TB] FAIL crcerr_suppressed: got %b want 0", crc_err); end
    endtask

    task automatic test_r3;
        do_arm(1'b0, 1'b0);
        drive_frame({88'b0, R3_OK}, 48, 7, -1);
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("[TB] FAIL r3_done: got %b want 1", done); end
        n_cmp++; if (rsp_data !== 128'h00FF8000) begin n_err++; $display("[TB] FAIL r3_data: got %h want ff8000", rsp_data); end
        n_cmp++; if (rsp_index !== 6'h3F) begin n_err++; $display("[TB] FAIL r3_index: got %h want 3f", rsp_index); end
        n_cmp++; if ({crc_err, end_err, tx_err} !== 3'b000) begin n_err++; $display("[TB] FAIL r3_flags: got %b want 000", {crc_err, end_err, tx_err}); end
    endtask

    task automatic test_timeout;
        int first;
        first = -1;
        do_arm(1'b0, 1'b1);
        cmd_in = 1'b1;
        for (int n = 1; n <= 200; n++) begin
            @(negedge CLK);
            if (done === 1'b1) begin
                first = n;
                break;
            end
        end
        n_cmp++; if (first !== 64) begin n_err++; $display("[TB] FAIL timeout_latency: got done %0d cycles after arm edge +1 want 64 (-1 = never)", first); end
        n_cmp++; if (timeout !== 1'b1) begin n_err++; $display("[TB] FAIL timeout_flag: got %b want 1", timeout); end
        n_cmp++; if ({rsp_index, rsp_data} !== 134'd0) begin n_err++; $display("[TB] FAIL timeout_fields: got %h/%h want 0", rsp_index, rsp_data); end
    endtask

    task automatic test_long;
        logic [135:0] f;
        f          = '0;
        f[135]     = 1'b0;
        f[134]     = 1'b0;
        f[133:128] = 6'h3F;
        f[127:8]   = 120'h03_5344_5355_3136_4780_1234_5678_00_9A;
        f[7:1]     = crc7_model(f, 127, 8);
        f[0]       = 1'b1;
        do_arm(1'b1, 1'b1);
        drive_frame(f, 136, 3, -1);
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("[TB] FAIL long_done: got %b want 1", done); end
        n_cmp++; if (rsp_data !== f[127:0]) begin n_err++; $display("[TB] FAIL long_data: got %h want %h", rsp_data, f[127:0]); end
        n_cmp++; if (rsp_index !== 6'h3F) begin n_err++; $display("[TB] FAIL long_index: got %h want 3f", rsp_index); end
        n_cmp++; if ({crc_err, end_err, tx_err} !== 3'b000) begin n_err++; $display("[TB] FAIL long_flags: got %b want 000", {crc_err, end_err, tx_err}); end
        f[0] = 1'b0;
        do_arm(1'b1, 1'b1);
        drive_frame(f, 136, 2, -1);
        n_cmp++; if ({crc_err, end_err} !== 2'b01) begin n_err++; $display("[TB] FAIL long_end_err: got crc/end %b want 01", {crc_err, end_err}); end
    endtask

    task automatic test_reset_mid_recv;
        logic saw_done;
        saw_done = 1'b0;
        do_arm(1'b0, 1'b1);
        cmd_in = 1'b1;
        @(negedge CLK);
        for (int i = 47; i >= 20; i--) begin
            cmd_in = R7_OK[i];
            @(negedge CLK);
        end
        RST = 1'b1;
        @(negedge CLK);
        RST    = 1'b0;
        cmd_in = 1'b1;
        n_cmp++; if ({busy, done} !== 2'b00) begin n_err++; $display("[TB] FAIL rstmid_handshake: got busy/done %b want 00", {busy, done}); end
        n_cmp++; if ({rsp_index, rsp_data, crc_err, end_err, tx_err, timeout} !== 138'd0) begin n_err++; $display("[TB] FAIL rstmid_outputs: got nonzero outputs"); end
        for (int n = 0; n < 80; n++) begin
            @(negedge CLK);
            if (done === 1'b1) saw_done = 1'b1;
        end
        n_cmp++; if (saw_done !== 1'b0) begin n_err++; $display("[TB] FAIL rstmid_no_done: got %b want 0", saw_done); end
        do_arm(1'b0, 1'b1);
        drive_frame({88'b0, R7_OK}, 48, 4, -1);
        n_cmp++; if ({done, rsp_index, rsp_data[31:0], crc_err} !== {1'b1, 6'h08, 32'h1AA, 1'b0}) begin n_err++; $display("[TB] FAIL rstmid_recover: got done %b idx %h data %h crc %b", done, rsp_index, rsp_data[31:0], crc_err); end
    endtask

    task automatic test_back_to_back;
        do_arm(1'b0, 1'b1);
        drive_frame({88'b0, R7_OK}, 48, 3, 30);
        n_cmp++; if ({done, rsp_index, rsp_data, crc_err} !== {1'b1, 6'h08, 128'h1AA, 1'b0}) begin n_err++; $display("[TB] FAIL b2b_arm_while_busy: got done %b idx %h data %h crc %b", done, rsp_index, rsp_data, crc_err); end
        // Arm during FIN must not start a new receive.
        arm = 1'b1; long_rsp = 1'b0; crc_chk_en = 1'b1;
        @(negedge CLK);
        arm = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL b2b_arm_in_fin: got busy %b want 0", busy); end
        do_arm(1'b0, 1'b0);
        drive_frame({88'b0, R3_OK}, 48, 0, -1);
        n_cmp++; if ({done, rsp_data[31:0]} !== {1'b1, 32'h00FF8000}) begin n_err++; $display("[TB] FAIL b2b_second: got done %b data %h", done, rsp_data[31:0]); end
    endtask

    initial begin
        test_reset();
        test_r7();
        test_crc_error();
        test_r3();
        test_timeout();
        test_long();
        test_reset_mid_recv();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
